// File: rtl/nonce_controller_if.sv
// Handshake and control bundle between nonce_controller and its neighbours:
// UART receive strobe, hasher status, nonce register controls and status.
interface nonce_controller_if #(
   parameter int COUNT_WIDTH = 32
);
   logic                   rx_valid_i;
   logic [7:0]             rx_data_i;
   logic                   hash_ready_i;
   logic                   found_i;
   logic                   shift_in_rx_data_o;
   logic                   increment_o;
   logic                   loaded_o;
   logic                   running_o;
   logic                   halted_o;
   logic [COUNT_WIDTH-1:0] attempts_o;

   modport master (
      output rx_valid_i, rx_data_i, hash_ready_i, found_i,
      input  shift_in_rx_data_o, increment_o, loaded_o,
      input  running_o, halted_o, attempts_o
   );

   modport slave (
      input  rx_valid_i, rx_data_i, hash_ready_i, found_i,
      output shift_in_rx_data_o, increment_o, loaded_o,
      output running_o, halted_o, attempts_o
   );
endinterface

// File: rtl/nonce_controller.sv
// Nonce load/run/halt sequencer driven by UART command bytes.
// Optional inter-byte LOAD timeout: define NONCE_CTRL_TIMEOUT_EN.
module nonce_controller #(
   parameter int NONCE_BYTES    = 32,
   parameter int COUNT_WIDTH    = 32,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input logic               clk_i,
   input logic               rst_i,
   nonce_controller_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_e;

   localparam int BW = $clog2(NONCE_BYTES + 1);
   localparam logic [7:0] CMD_L = 8'h4C;
   localparam logic [7:0] CMD_G = 8'h47;
   localparam logic [7:0] CMD_S = 8'h53;

   state_e                 state_q, state_d;
   logic [BW-1:0]          bcnt_q, bcnt_d;
   logic                   loaded_q, loaded_d;
   logic [COUNT_WIDTH-1:0] att_q, att_d;
   logic                   cmd_l, cmd_g, cmd_s;
   logic                   shift, inc, timeout;

   assign cmd_l = bus.rx_valid_i && (bus.rx_data_i == CMD_L);
   assign cmd_g = bus.rx_valid_i && (bus.rx_data_i == CMD_G);
   assign cmd_s = bus.rx_valid_i && (bus.rx_data_i == CMD_S);

   assign shift = (state_q == LOAD) && bus.rx_valid_i;
   assign inc   = (state_q == RUN) && !bus.found_i;

`ifdef NONCE_CTRL_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] tcnt_q, tcnt_d;

   assign timeout = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

   // Idle-cycle counter, held at zero outside LOAD and on every byte
   always_comb begin
      tcnt_d = '0;
      if (state_q == LOAD && !bus.rx_valid_i && !timeout)
         tcnt_d = tcnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) tcnt_q <= '0;
      else       tcnt_q <= tcnt_d;
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      bcnt_d   = bcnt_q;
      loaded_d = loaded_q;
      att_d    = att_q;
      if (inc && bus.hash_ready_i && (att_q != '1))
         att_d = att_q + 1'b1;
      unique case (state_q)
         IDLE: begin
            if (cmd_l) begin
               state_d  = LOAD;
               bcnt_d   = '0;
               loaded_d = 1'b0;
            end else if (cmd_g && loaded_q) begin
               state_d = RUN;
               att_d   = '0;
            end
         end
         LOAD: begin
            if (bus.rx_valid_i) begin
               bcnt_d = bcnt_q + 1'b1;
               if (bcnt_q == BW'(NONCE_BYTES - 1)) begin
                  state_d  = IDLE;
                  loaded_d = 1'b1;
               end
            end else if (timeout) begin
               state_d = IDLE;
            end
         end
         RUN: begin
            // A hit outranks any command arriving in the same cycle
            if (bus.found_i) begin
               state_d = HALT;
            end else if (cmd_s) begin
               state_d = IDLE;
            end else if (cmd_l) begin
               state_d  = LOAD;
               bcnt_d   = '0;
               loaded_d = 1'b0;
            end
         end
         HALT: begin
            unique case (1'b1)
               cmd_g: state_d = RUN;
               cmd_s: state_d = IDLE;
               cmd_l: begin
                  state_d  = LOAD;
                  bcnt_d   = '0;
                  loaded_d = 1'b0;
               end
               default: state_d = HALT;
            endcase
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         bcnt_q   <= '0;
         loaded_q <= 1'b0;
         att_q    <= '0;
      end else begin
         state_q  <= state_d;
         bcnt_q   <= bcnt_d;
         loaded_q <= loaded_d;
         att_q    <= att_d;
      end
   end

   assign bus.shift_in_rx_data_o = shift;
   assign bus.increment_o        = inc;
   assign bus.loaded_o           = loaded_q;
   assign bus.running_o          = (state_q == RUN);
   assign bus.halted_o           = (state_q == HALT);
   assign bus.attempts_o         = att_q;
endmodule

// File: tb/tb_nonce_controller.sv
// Randomized bench for nonce_controller with a behavioural model of the
// command sequencing and of the attached 256-bit nonce register.
module tb_nonce_controller;
   localparam int NB = 32;
   localparam logic [7:0] C_L = 8'h4C;
   localparam logic [7:0] C_G = 8'h47;
   localparam logic [7:0] C_S = 8'h53;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rv = 1'b0;
   logic [7:0] rd = 8'h00;
   logic hr = 1'b0;
   logic fd = 1'b0;

   always #5 clk = ~clk;

   nonce_controller_if #(.COUNT_WIDTH(32)) bus32 ();
   nonce_controller_if #(.COUNT_WIDTH(4))  bus4 ();

   assign bus32.rx_valid_i   = rv;
   assign bus32.rx_data_i    = rd;
   assign bus32.hash_ready_i = hr;
   assign bus32.found_i      = fd;
   assign bus4.rx_valid_i    = rv;
   assign bus4.rx_data_i     = rd;
   assign bus4.hash_ready_i  = hr;
   assign bus4.found_i       = fd;

   nonce_controller #(
      .NONCE_BYTES(NB), .COUNT_WIDTH(32), .TIMEOUT_CYCLES(16)
   ) dut (.clk_i(clk), .rst_i(rst), .bus(bus32));

   nonce_controller #(
      .NONCE_BYTES(NB), .COUNT_WIDTH(4), .TIMEOUT_CYCLES(16)
   ) dut4 (.clk_i(clk), .rst_i(rst), .bus(bus4));

   // Nonce register attached to the controller outputs
   logic [255:0] nreg;
   always @(posedge clk) begin
      if (bus32.shift_in_rx_data_o)
         nreg <= {rd, nreg[255:8]};
      else if (bus32.increment_o && hr)
         nreg <= nreg + 256'd1;
   end

   int shift_cnt = 0;
   int inc_cnt = 0;
   int inc_on_found = 0;
   int overlap = 0;
   always @(posedge clk) begin
      if (!rst) begin
         if (bus32.shift_in_rx_data_o) shift_cnt <= shift_cnt + 1;
         if (bus32.increment_o) inc_cnt <= inc_cnt + 1;
         if (bus32.increment_o && fd) inc_on_found <= inc_on_found + 1;
         if (bus32.shift_in_rx_data_o && bus32.increment_o)
            overlap <= overlap + 1;
      end
   end

   typedef enum {M_IDLE, M_LOAD, M_RUN, M_HALT} mode_t;
   mode_t  m_mode = M_IDLE;
   int     m_bytes = 0;
   int     m_idle = 0;
   bit     m_loaded = 1'b0;
   longint m_att = 0;
   longint m_att4 = 0;

   int errors = 0;
   int checks = 0;

   function automatic longint sat_inc(longint v, int w);
      longint top = (longint'(1) << w) - 1;
      return (v >= top) ? top : v + 1;
   endfunction

   task automatic model_start_load();
      m_mode = M_LOAD;
      m_bytes = 0;
      m_idle = 0;
      m_loaded = 1'b0;
   endtask

   task automatic model_step(bit v, logic [7:0] d, bit r, bit f);
      bit isl = v && (d == C_L);
      bit isg = v && (d == C_G);
      bit iss = v && (d == C_S);
      case (m_mode)
         M_IDLE: begin
            if (isl) model_start_load();
            else if (isg && m_loaded) begin
               m_mode = M_RUN;
               m_att = 0;
               m_att4 = 0;
            end
         end
         M_LOAD: begin
            if (v) begin
               m_bytes++;
               m_idle = 0;
               if (m_bytes == NB) begin
                  m_mode = M_IDLE;
                  m_loaded = 1'b1;
               end
            end else begin
               m_idle++;
`ifdef NONCE_CTRL_TIMEOUT_EN
               if (m_idle == 16) m_mode = M_IDLE;
`endif
            end
         end
         M_RUN: begin
            if (!f && r) begin
               m_att = sat_inc(m_att, 32);
               m_att4 = sat_inc(m_att4, 4);
            end
            if (f) m_mode = M_HALT;
            else if (iss) m_mode = M_IDLE;
            else if (isl) model_start_load();
         end
         M_HALT: begin
            if (isg) m_mode = M_RUN;
            else if (iss) m_mode = M_IDLE;
            else if (isl) model_start_load();
         end
      endcase
   endtask

   task automatic cyc(bit v, logic [7:0] d, bit r, bit f);
      @(negedge clk);
      rv = v;
      rd = d;
      hr = r;
      fd = f;
      @(posedge clk);
      model_step(v, d, r, f);
      #1;
      rv = 1'b0;
      hr = 1'b0;
      fd = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      rv = 1'b0;
      hr = 1'b0;
      fd = 1'b0;
      repeat (2) @(negedge clk);
      m_mode = M_IDLE;
      m_bytes = 0;
      m_idle = 0;
      m_loaded = 1'b0;
      m_att = 0;
      m_att4 = 0;
      rst = 1'b0;
   endtask

   task automatic load_random(output logic [255:0] val);
      logic [7:0] b;
      cyc(1'b1, C_L, 1'b0, 1'b0);
      for (int i = 0; i < NB; i++) begin
         b = 8'($urandom);
         val[i*8 +: 8] = b;
         repeat ($urandom_range(0, 3)) cyc(1'b0, 8'h00, 1'b0, 1'b0);
         cyc(1'b1, b, 1'b0, 1'b0);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      #2;
      checks++;
      if ({bus32.shift_in_rx_data_o, bus32.increment_o, bus32.loaded_o,
           bus32.running_o, bus32.halted_o, bus32.attempts_o} !== 37'd0) begin
         errors++;
         $display("FAIL reset_during: outputs=%h want 0", {bus32.loaded_o,
                  bus32.running_o, bus32.halted_o, bus32.attempts_o});
      end
      do_reset();
      #1;
      checks++;
      if ({bus32.shift_in_rx_data_o, bus32.increment_o, bus32.loaded_o,
           bus32.running_o, bus32.halted_o, bus32.attempts_o,
           bus4.attempts_o} !== 41'd0) begin
         errors++;
         $display("FAIL reset_after: att=%h att4=%h want 0",
                  bus32.attempts_o, bus4.attempts_o);
      end
   endtask

   task automatic test_load_sequence();
      logic [255:0] exp;
      int s0 = shift_cnt;
      cyc(1'b1, C_L, 1'b0, 1'b0);
      for (int i = 0; i < NB; i++) begin
         exp[i*8 +: 8] = 8'(i);
         repeat ($urandom_range(0, 3)) cyc(1'b0, 8'h00, 1'b0, 1'b0);
         cyc(1'b1, 8'(i), 1'b0, 1'b0);
         if (i == NB - 2) begin
            checks++;
            if (bus32.loaded_o !== 1'b0) begin
               errors++;
               $display("FAIL load_partial: loaded=%b want 0", bus32.loaded_o);
            end
         end
      end
      checks++;
      if (shift_cnt - s0 !== NB) begin
         errors++;
         $display("FAIL load_pulses: got %0d want %0d", shift_cnt - s0, NB);
      end
      checks++;
      if ({bus32.loaded_o, bus32.running_o, bus32.halted_o} !== {m_loaded, 2'b00}) begin
         errors++;
         $display("FAIL load_done: l/r/h=%b%b%b want %b00", bus32.loaded_o,
                  bus32.running_o, bus32.halted_o, m_loaded);
      end
      checks++;
      if (nreg !== exp) begin
         errors++;
         $display("FAIL load_nonce: got %h want %h", nreg, exp);
      end
   endtask

   task automatic test_go_unloaded();
      int i0;
      do_reset();
      i0 = inc_cnt;
      cyc(1'b1, C_G, 1'b1, 1'b0);
      repeat (4) cyc(1'b0, 8'h00, 1'b1, 1'b0);
      checks++;
      if (inc_cnt - i0 !== 0) begin
         errors++;
         $display("FAIL go_unloaded_inc: got %0d want 0", inc_cnt - i0);
      end
      checks++;
      if ({bus32.running_o, bus32.loaded_o} !== 2'b00) begin
         errors++;
         $display("FAIL go_unloaded_state: run=%b loaded=%b want 0 0",
                  bus32.running_o, bus32.loaded_o);
      end
   endtask

   task automatic test_run_found();
      logic [255:0] val;
      int n = 0;
      int guard = 0;
      int f0;
      load_random(val);
      cyc(1'b1, C_G, 1'b0, 1'b0);
      checks++;
      if ({bus32.running_o, bus32.increment_o} !== 2'b11) begin
         errors++;
         $display("FAIL go_first_inc: run=%b inc=%b want 1 1",
                  bus32.running_o, bus32.increment_o);
      end
      while (n < 5 && guard < 200) begin
         bit r = 1'($urandom_range(0, 1));
         cyc(1'b0, 8'h00, r, 1'b0);
         if (r) n++;
         guard++;
      end
      f0 = inc_on_found;
      cyc(1'b0, 8'h00, 1'b1, 1'b1);
      checks++;
      if (inc_on_found - f0 !== 0) begin
         errors++;
         $display("FAIL found_inc_drop: got %0d want 0", inc_on_found - f0);
      end
      checks++;
      if (bus32.attempts_o !== 32'(m_att) || m_att != 5) begin
         errors++;
         $display("FAIL found_attempts: got %0d want 5", bus32.attempts_o);
      end
      checks++;
      if ({bus32.halted_o, bus32.running_o} !== 2'b10) begin
         errors++;
         $display("FAIL found_halt: halt=%b run=%b want 1 0",
                  bus32.halted_o, bus32.running_o);
      end
      checks++;
      if (nreg !== val + 256'd5) begin
         errors++;
         $display("FAIL found_nonce: got %h want %h", nreg, val + 256'd5);
      end
   endtask

   task automatic test_stop_vs_found();
      longint a0;
      cyc(1'b1, C_G, 1'b0, 1'b0);
      checks++;
      if (bus32.running_o !== 1'b1 || bus32.attempts_o !== 32'(m_att)) begin
         errors++;
         $display("FAIL resume: run=%b att=%0d want 1 %0d",
                  bus32.running_o, bus32.attempts_o, m_att);
      end
      repeat ($urandom_range(3, 9)) cyc(1'b0, 8'h00, 1'($urandom), 1'b0);
      cyc(1'b1, C_S, 1'b1, 1'b1);
      a0 = m_att;
      checks++;
      if ({bus32.halted_o, bus32.running_o} !== 2'b10 ||
          bus32.attempts_o !== 32'(m_att)) begin
         errors++;
         $display("FAIL stop_found_same: halt=%b att=%0d want 1 %0d",
                  bus32.halted_o, bus32.attempts_o, m_att);
      end
      cyc(1'b1, C_G, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      checks++;
      if (bus32.running_o !== 1'b1 || bus32.attempts_o !== 32'(a0)) begin
         errors++;
         $display("FAIL resume_keep: run=%b att=%0d want 1 %0d",
                  bus32.running_o, bus32.attempts_o, a0);
      end
   endtask

   task automatic test_saturate();
      cyc(1'b1, C_S, 1'b0, 1'b0);
      checks++;
      if ({bus32.running_o, bus32.halted_o, bus32.loaded_o} !== 3'b001) begin
         errors++;
         $display("FAIL stop_idle: r/h/l=%b%b%b want 001", bus32.running_o,
                  bus32.halted_o, bus32.loaded_o);
      end
      cyc(1'b1, C_G, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         if (i == 14) begin
            checks++;
            if (bus4.attempts_o !== 4'hF) begin
               errors++;
               $display("FAIL sat_edge: got %h want f", bus4.attempts_o);
            end
         end
      end
      checks++;
      if (bus4.attempts_o !== 4'(m_att4) || m_att4 != 15) begin
         errors++;
         $display("FAIL sat_hold: got %h want f", bus4.attempts_o);
      end
      checks++;
      if (bus32.attempts_o !== 32'(m_att) || m_att != 20) begin
         errors++;
         $display("FAIL sat_wide: got %0d want 20", bus32.attempts_o);
      end
      cyc(1'b1, C_L, 1'b1, 1'b0);
      checks++;
      if ({bus32.running_o, bus32.loaded_o, bus32.increment_o} !== 3'b000) begin
         errors++;
         $display("FAIL run_to_load: r/l/i=%b%b%b want 000", bus32.running_o,
                  bus32.loaded_o, bus32.increment_o);
      end
   endtask

   task automatic test_timeout();
      int s0;
      int exp_shift;
      do_reset();
      cyc(1'b1, C_L, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
      repeat (16) cyc(1'b0, 8'h00, 1'b0, 1'b0);
      s0 = shift_cnt;
      cyc(1'b1, C_G, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
`ifdef NONCE_CTRL_TIMEOUT_EN
      exp_shift = 0;
`else
      exp_shift = 1;
`endif
      checks++;
      if (shift_cnt - s0 !== exp_shift || m_bytes != 3 + exp_shift) begin
         errors++;
         $display("FAIL timeout_shift: got %0d want %0d", shift_cnt - s0,
                  exp_shift);
      end
      checks++;
      if ({bus32.loaded_o, bus32.running_o} !== 2'b00) begin
         errors++;
         $display("FAIL timeout_state: loaded=%b run=%b want 0 0",
                  bus32.loaded_o, bus32.running_o);
      end
   endtask

   task automatic test_async_reset();
      logic [255:0] val;
      do_reset();
      load_random(val);
      cyc(1'b1, C_G, 1'b0, 1'b0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({bus32.running_o, bus32.loaded_o, bus32.increment_o} !== 3'b000) begin
         errors++;
         $display("FAIL async_rst_run: r/l/i=%b%b%b want 000",
                  bus32.running_o, bus32.loaded_o, bus32.increment_o);
      end
      do_reset();
      cyc(1'b1, C_L, 1'b0, 1'b0);
      repeat (5) cyc(1'b1, 8'($urandom), 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      rv = 1'b1;
      #1;
      checks++;
      if ({bus32.shift_in_rx_data_o, bus32.loaded_o} !== 2'b00) begin
         errors++;
         $display("FAIL async_rst_load: shift=%b loaded=%b want 0 0",
                  bus32.shift_in_rx_data_o, bus32.loaded_o);
      end
      rv = 1'b0;
      do_reset();
   endtask

   initial begin
      test_reset();
      test_load_sequence();
      test_go_unloaded();
      test_run_found();
      test_stop_vs_found();
      test_saturate();
      test_timeout();
      test_async_reset();
      checks++;
      if (overlap !== 0) begin
         errors++;
         $display("FAIL shift_inc_overlap: got %0d want 0", overlap);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: sim time exceeded, want finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/nonce_controller.md
# nonce_controller

Sequencer for the 256-bit nonce register. It parses UART receive bytes into single-byte commands and steers the nonce register's `shift_in_rx_data_i` and `increment_i` controls. It loads a 32-byte nonce (LSB byte first), runs the increment loop against the hasher's ready signal, halts when the hasher reports a hit, and counts attempts. It sits between the UART receiver, the nonce register and the Skein hash core. The controller drives control lines only; the nonce register takes `rx_data_i` straight from the UART.

## Interface
Parameters:
- `NONCE_BYTES`, 32, bytes per nonce load (must match nonce register width / 8)
- `COUNT_WIDTH`, 32, width of attempt counter
- `TIMEOUT_CYCLES`, 1_000_000, inter-byte timeout in LOAD (used only with `NONCE_CTRL_TIMEOUT_EN`)

Ports:
- `clk_i` input 1: single clock; all state updates on posedge
- `rst_i` input 1: asynchronous, active-high reset
- `rx_valid_i` input 1: one-cycle strobe, `rx_data_i` valid
- `rx_data_i` input 8: received byte
- `hash_ready_i` input 1: hasher accepts a new nonce this cycle (same signal as nonce register `ready_i`)
- `found_i` input 1: hasher reports a qualifying hash for the current nonce
- `shift_in_rx_data_o` output 1: to nonce register `shift_in_rx_data_i`
- `increment_o` output 1: to nonce register `increment_i`
- `loaded_o` output 1: a complete nonce has been loaded since the last LOAD entry
- `running_o` output 1: state == RUN
- `halted_o` output 1: state == HALT
- `attempts_o` output COUNT_WIDTH: accepted increments since last start

## Operation
- States: IDLE, LOAD, RUN, HALT. Reset → IDLE, byte counter 0, `loaded_o` 0, `attempts_o` 0, timeout counter 0. All outputs are 0 during and immediately after reset.
- Commands are decoded only when `rx_valid_i`=1 and the state is not LOAD: 'L' 0x4C, 'G' 0x47, 'S' 0x53. Other bytes are ignored.
- IDLE:
  - 'L' → LOAD; clear byte counter and `loaded_o`.
  - 'G' with `loaded_o`=1 → RUN; clear `attempts_o`.
  - 'G' with `loaded_o`=0 is ignored.
- LOAD:
  - Every `rx_valid_i` byte is nonce data, never a command.
  - `shift_in_rx_data_o` = `rx_valid_i` (combinational); byte counter increments.
  - On byte number NONCE_BYTES → IDLE, `loaded_o`=1.
- RUN:
  - `increment_o` = ~`found_i` (combinational).
  - An attempt is counted when `increment_o` & `hash_ready_i`. `attempts_o` saturates at all-ones and never wraps.
  - `found_i`=1 → HALT.
  - 'S' → IDLE.
  - 'L' → LOAD.
  - If `found_i` and a command arrive in the same cycle, `found_i` wins → HALT; the command is dropped.
- HALT:
  - `increment_o`=0; the nonce is held for readout.
  - 'G' → RUN; `attempts_o` is not cleared (resume).
  - 'S' → IDLE.
  - 'L' → LOAD.
- `shift_in_rx_data_o` and `increment_o` are never high together.

## Timing
- `shift_in_rx_data_o` is high in the same cycle as `rx_valid_i`. The nonce register captures the byte at that clock edge.
- State transitions take effect at the edge that samples the triggering input. The new state's outputs are valid the following cycle.
- `increment_o` drops combinationally in the cycle `found_i` rises. The nonce is therefore not advanced past the hit.
- First increment after 'G': the 'G' byte is sampled at edge N, and `increment_o`=1 from cycle N+1.
- `attempts_o` is registered, so it lags the accepted increment by one cycle.
- An asynchronous `rst_i` during LOAD or RUN returns to IDLE immediately. A partial nonce is left in the nonce register and `loaded_o`=0.

## Configuration
- `NONCE_CTRL_TIMEOUT_EN` defined:
  - In LOAD, a counter runs between bytes and restarts on each `rx_valid_i`.
  - Reaching TIMEOUT_CYCLES without a byte → IDLE with `loaded_o`=0 (the load is aborted).
- `NONCE_CTRL_TIMEOUT_EN` undefined:
  - There is no timeout counter; LOAD waits indefinitely.
  - The `TIMEOUT_CYCLES` parameter is unused.

## Test plan
- Reset, then 'L' followed by 32 bytes 0x00..0x1F → exactly 32 `shift_in_rx_data_o` pulses, then IDLE with `loaded_o`=1, and the nonce register holds 0x1F1E..0100.
- 'G' in IDLE with `loaded_o`=0 → stays IDLE, `increment_o` never asserted.
- Load, 'G', `hash_ready_i` high on 5 cycles, then `found_i` → `attempts_o`=5, HALT, `increment_o`=0 in the `found_i` cycle, nonce = loaded+5.
- In RUN, 'S' and `found_i` on the same cycle → HALT; then 'G' → RUN with `attempts_o` unchanged.
- With `COUNT_WIDTH`=4: 20 accepted increments → `attempts_o` saturates at 0xF.
- `NONCE_CTRL_TIMEOUT_EN` with TIMEOUT_CYCLES=16: 'L', 3 bytes, 16 idle cycles → IDLE with `loaded_o`=0; without the macro → remains in LOAD.
